// File: rtl/vmu_pkg.sv
// ---------------------------------------------------------------------------
// vmu_pkg
// Shared definitions for the VMU request path: sizing constants, the
// request-issue FSM state type, the per-beat request record and a helper
// that derives the final-beat lane mask from an element count.
// ---------------------------------------------------------------------------
package vmu_pkg;

   localparam int SCALAR_WIDTH   = 32;
   localparam int SYS_NUM_LANE   = 8;
   localparam int SYS_VLMAX      = 256;

   localparam int VL_WIDTH       = $clog2(SYS_VLMAX) + 1;
   localparam int LANE_IDX_WIDTH = $clog2(SYS_NUM_LANE);
   localparam int BEAT_WIDTH     = $clog2(SYS_VLMAX / SYS_NUM_LANE) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_e;

   typedef struct packed {
      logic [SCALAR_WIDTH-1:0] addr;
      logic [SYS_NUM_LANE-1:0] mask;
      logic                    last;
   } req_t;

   // Lanes covered by the final beat: the low (vl mod lanes) bits, or the
   // whole beat when vl is an exact multiple of the beat width.
   function automatic logic [SYS_NUM_LANE-1:0] tail_mask(input logic [VL_WIDTH-1:0] vl);
      logic [LANE_IDX_WIDTH-1:0] rem;
      logic [SYS_NUM_LANE-1:0]   ones;
      rem  = vl[LANE_IDX_WIDTH-1:0];
      ones = '1;
      tail_mask = (rem == '0) ? ones : ~(ones << rem);
   endfunction

endpackage

// File: rtl/vmu_tail_mask.sv
// ---------------------------------------------------------------------------
// vmu_tail_mask
// Combinational lane-mask generator for the last beat of a vector op.
// Shared with the load/store data aligners, so it takes only the element
// remainder rather than the full vector length.
//
// Ports:
//   rem   in   $clog2(NUM_LANE)  vl modulo NUM_LANE
//   mask  out  NUM_LANE          active-lane mask, bit i = lane i
// ---------------------------------------------------------------------------
module vmu_tail_mask #(
   parameter int NUM_LANE = 8
) (
   input  logic [$clog2(NUM_LANE)-1:0] rem,
   output logic [NUM_LANE-1:0]         mask
);

   logic [NUM_LANE-1:0] ones;

   // A zero remainder means the op ends on a full beat, so every lane is live.
   always_comb begin
      ones = '1;
      mask = ones;
      if (rem != '0) begin
         mask = ~(ones << rem);
      end
   end

endmodule

// File: rtl/vmu_req_issue.sv
// ---------------------------------------------------------------------------
// vmu_req_issue
// Expands one vector memory op into a sequence of per-beat requests to the
// VMU memory port. Beat k targets base + k*stride; every beat but the last
// enables all lanes, the last one enables only the lanes the op covers.
// Requests are held stable under back-pressure.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_start       launch pulse, honoured only while idle
//   i_base_addr   first-beat address, captured at launch
//   i_stride      byte increment per beat, captured at launch
//   i_vl          element count 0..SYS_VLMAX, captured at launch
//   o_busy        op in progress (issue or completion cycle)
//   o_req_valid   request valid toward the memory port
//   i_req_ready   memory port accepts the request
//   o_req_addr    beat address
//   o_req_mask    active-lane mask
//   o_req_last    final beat of the op
//   o_done        one-cycle completion pulse
// ---------------------------------------------------------------------------
module vmu_req_issue
   import vmu_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_start,
   input  logic [SCALAR_WIDTH-1:0] i_base_addr,
   input  logic [SCALAR_WIDTH-1:0] i_stride,
   input  logic [VL_WIDTH-1:0]     i_vl,
   output logic                    o_busy,
   output logic                    o_req_valid,
   input  logic                    i_req_ready,
   output logic [SCALAR_WIDTH-1:0] o_req_addr,
   output logic [SYS_NUM_LANE-1:0] o_req_mask,
   output logic                    o_req_last,
   output logic                    o_done
);

   localparam logic [BEAT_WIDTH-1:0] ONE_BEAT  = BEAT_WIDTH'(1);
   localparam logic [BEAT_WIDTH-1:0] TWO_BEATS = BEAT_WIDTH'(2);

   state_e                  state;
   req_t                    req;
   logic [SCALAR_WIDTH-1:0] stride_q;
   logic [SYS_NUM_LANE-1:0] tail_q;
   logic [SYS_NUM_LANE-1:0] start_tail;
   logic [BEAT_WIDTH-1:0]   beats_left;
   logic [BEAT_WIDTH-1:0]   start_beats;
   logic                    handshake;

   vmu_tail_mask #(
      .NUM_LANE (SYS_NUM_LANE)
   ) u_tail_mask (
      .rem  (i_vl[LANE_IDX_WIDTH-1:0]),
      .mask (start_tail)
   );

   // Beats needed for the op: ceil(vl / lanes), done as a shift plus a
   // round-up bit for any partial tail.
   always_comb begin
      start_beats = BEAT_WIDTH'(i_vl >> LANE_IDX_WIDTH)
                  + BEAT_WIDTH'(|i_vl[LANE_IDX_WIDTH-1:0]);
   end

   assign handshake = (state == ISSUE) && i_req_ready;

   // beats_left counts the beats not yet accepted, including the one being
   // presented, so the beat after the current one is the last exactly when
   // two remain. The address advances by stride only on acceptance, which
   // keeps the presented request frozen while the port stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         req        <= '0;
         stride_q   <= '0;
         tail_q     <= '0;
         beats_left <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  if (i_vl == '0) begin
                     state <= DONE;
                  end else begin
                     state      <= ISSUE;
                     req.addr   <= i_base_addr;
                     req.last   <= (start_beats == ONE_BEAT);
                     req.mask   <= (start_beats == ONE_BEAT) ? start_tail : '1;
                     stride_q   <= i_stride;
                     tail_q     <= start_tail;
                     beats_left <= start_beats;
                  end
               end
            end
            ISSUE: begin
               if (handshake) begin
                  if (req.last) begin
                     state      <= DONE;
                     req        <= '0;
                     beats_left <= '0;
                  end else begin
                     req.addr   <= req.addr + stride_q;
                     req.last   <= (beats_left == TWO_BEATS);
                     req.mask   <= (beats_left == TWO_BEATS) ? tail_q : '1;
                     beats_left <= beats_left - ONE_BEAT;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign o_busy      = (state != IDLE);
   assign o_req_valid = (state == ISSUE);
   assign o_done      = (state == DONE);
   assign o_req_addr  = req.addr;
   assign o_req_mask  = req.mask;
   assign o_req_last  = req.last;

endmodule
